// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Holds the controller state encoding, address-field width helpers and the
// halfword straddle/select helpers used by the lookup path.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        INSTALL
    } state_t;

    // Address fields: tag | set | word | byte(2)
    function automatic int tag_width(input int set_bit, input int line_bit);
        return 32 - set_bit - line_bit - 2;
    endfunction

    function automatic int set_width(input int set_bit);
        return set_bit;
    endfunction

    function automatic int word_width(input int line_bit);
        return line_bit;
    endfunction

    // A halfword-aligned fetch in the last word of a line spills into the next line.
    function automatic logic is_straddle(input logic [31:0] addr, input int line_bit);
        logic [31:0] mask;
        mask = (32'd1 << line_bit) - 32'd1;
        return addr[1] && (((addr >> 2) & mask) == mask);
    endfunction

    // Assemble the instruction: low half at A, high half at A+2.
    function automatic logic [31:0] select_half(input logic [31:0] lo_word,
                                                input logic [15:0] hi_half,
                                                input logic        odd_half);
        return odd_half ? {hi_half, lo_word[31:16]} : lo_word;
    endfunction

endpackage

// File: rtl/icache_way_array.sv
// One way of the instruction cache: per-set valid bit, tag and full line.
// Ports:
//   clk_in, rst_in           clock, async active-high reset (valid bits only)
//   rd_set_a / rd_*_a        combinational read port A (valid, tag, line)
//   rd_set_b / rd_*_b        combinational read port B (valid, tag, line)
//   wr_en, wr_set, wr_tag,
//   wr_line                  line-wide install port
//   clear                    invalidate every set (takes priority over wr_en)
module icache_way_array
    import icache_pkg::*;
#(
    parameter  int SET_BIT  = 4,
    parameter  int LINE_BIT = 2,
    localparam int TAG_W    = tag_width(SET_BIT, LINE_BIT),
    localparam int SET_W    = set_width(SET_BIT),
    localparam int LINE_W   = 32 << LINE_BIT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [SET_W-1:0]  rd_set_a,
    output logic              rd_valid_a,
    output logic [TAG_W-1:0]  rd_tag_a,
    output logic [LINE_W-1:0] rd_line_a,
    input  logic [SET_W-1:0]  rd_set_b,
    output logic              rd_valid_b,
    output logic [TAG_W-1:0]  rd_tag_b,
    output logic [LINE_W-1:0] rd_line_b,
    input  logic              wr_en,
    input  logic [SET_W-1:0]  wr_set,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line,
    input  logic              clear
);

    localparam int SETS = 1 << SET_BIT;

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_set] <= 1'b1;
        end
    end

    // NOTE: tag/data storage has no reset; the valid bits alone qualify it, which keeps it RAM-mappable.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[wr_set]  <= wr_tag;
            data_q[wr_set] <= wr_line;
        end
    end

    assign rd_valid_a = valid_q[rd_set_a];
    assign rd_tag_a   = tag_q[rd_set_a];
    assign rd_line_a  = data_q[rd_set_a];
    assign rd_valid_b = valid_q[rd_set_b];
    assign rd_tag_b   = tag_q[rd_set_b];
    assign rd_line_b  = data_q[rd_set_b];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with multi-word lines, halfword-aligned
// fetches that may straddle two lines, round-robin victims per set and a
// global invalidate.  SET_BIT and LINE_BIT must be at least 1.
// Ports:
//   clk_in, rst_in, rdy_in      clock, async active-high reset, global stall
//   inst_valid, inst_addr       fetch request (held until inst_ready)
//   inst_ready, inst_res        one-cycle result pulse and instruction bits
//   mem_req, mem_addr           line refill request and line-aligned address
//   mem_beat, mem_data          refill words, ascending order
//   rob_clear                   squash the current fetch
//   flush                       invalidate every line
module icache_assoc
    import icache_pkg::*;
#(
    parameter int WAYS     = 2,
    parameter int SET_BIT  = 4,
    parameter int LINE_BIT = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        inst_valid,
    input  logic [31:0] inst_addr,
    output logic        inst_ready,
    output logic [31:0] inst_res,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_beat,
    input  logic [31:0] mem_data,
    input  logic        rob_clear,
    input  logic        flush
);

    localparam int TAG_W  = tag_width(SET_BIT, LINE_BIT);
    localparam int SET_W  = set_width(SET_BIT);
    localparam int WORD_W = word_width(LINE_BIT);
    localparam int LINE_W = 32 << LINE_BIT;
    localparam int SETS   = 1 << SET_BIT;
    localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SET_LO = LINE_BIT + 2;
    localparam int TAG_LO = SET_BIT + LINE_BIT + 2;

    state_t                     state;
    logic [WORD_W-1:0]          beat_q;
    logic [LINE_W-1:0]          line_buf;
    logic [TAG_W-1:0]           fill_tag;
    logic [SET_W-1:0]           fill_set;
    logic                       flush_pend;
    logic [SETS-1:0][PTR_W-1:0] ptr_q;

    // Low half lives at A, high half at A+2 (word address A[31:2] + A[1]).
    logic [TAG_W-1:0]  lo_tag, hi_tag;
    logic [SET_W-1:0]  lo_set, hi_set;
    logic [WORD_W-1:0] lo_word, hi_word;
    logic [29:0]       hi_wa;
    logic              straddle;

    assign lo_tag   = inst_addr[31:TAG_LO];
    assign lo_set   = inst_addr[TAG_LO-1:SET_LO];
    assign lo_word  = inst_addr[SET_LO-1:2];
    assign hi_wa    = inst_addr[31:2] + 30'(inst_addr[1]);
    assign hi_tag   = hi_wa[29:TAG_LO-2];
    assign hi_set   = hi_wa[TAG_LO-3:SET_LO-2];
    assign hi_word  = hi_wa[SET_LO-3:0];
    assign straddle = is_straddle(inst_addr, LINE_BIT);

    // Port A looks up the low line while idle and reads the fill set's
    // valid bits during INSTALL for victim selection; port B serves the high line.
    logic [SET_W-1:0]  rd_set_a;
    logic              way_valid_a [WAYS];
    logic [TAG_W-1:0]  way_tag_a   [WAYS];
    logic [LINE_W-1:0] way_line_a  [WAYS];
    logic              way_valid_b [WAYS];
    logic [TAG_W-1:0]  way_tag_b   [WAYS];
    logic [LINE_W-1:0] way_line_b  [WAYS];
    logic [WAYS-1:0]   way_we;
    logic              clear_all;

    assign rd_set_a = (state == IDLE) ? lo_set : fill_set;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way_array #(
            .SET_BIT  (SET_BIT),
            .LINE_BIT (LINE_BIT)
        ) u_way (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .rd_set_a   (rd_set_a),
            .rd_valid_a (way_valid_a[w]),
            .rd_tag_a   (way_tag_a[w]),
            .rd_line_a  (way_line_a[w]),
            .rd_set_b   (hi_set),
            .rd_valid_b (way_valid_b[w]),
            .rd_tag_b   (way_tag_b[w]),
            .rd_line_b  (way_line_b[w]),
            .wr_en      (way_we[w]),
            .wr_set     (fill_set),
            .wr_tag     (fill_tag),
            .wr_line    (line_buf),
            .clear      (clear_all)
        );
    end

    logic              lo_hit, hi_hit;
    logic [LINE_W-1:0] lo_line, hi_line, hi_src;
    logic [31:0]       lo_data;
    logic [15:0]       hi_half;
    logic [31:0]       fetch_res;
    logic [PTR_W-1:0]  victim;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        lo_hit  = 1'b0;
        hi_hit  = 1'b0;
        lo_line = '0;
        hi_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_valid_a[w] && (way_tag_a[w] == lo_tag)) begin
                lo_hit  = 1'b1;
                lo_line = way_line_a[w];
            end
            if (way_valid_b[w] && (way_tag_b[w] == hi_tag)) begin
                hi_hit  = 1'b1;
                hi_line = way_line_b[w];
            end
        end
    end

    // Without a straddle the high half comes from the same line as the low half.
    assign hi_src    = straddle ? hi_line : lo_line;
    assign lo_data   = lo_line[{lo_word, 5'b0} +: 32];
    assign hi_half   = hi_src[{hi_word, 5'b0} +: 16];
    assign fetch_res = select_half(lo_data, hi_half, inst_addr[1]);

    // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        victim = ptr_q[fill_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid_a[w]) victim = PTR_W'(w);
        end
    end

    always_comb begin
        way_we = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_we[w] = rdy_in && (state == INSTALL) && (victim == PTR_W'(w));
        end
    end

    assign clear_all = rdy_in && (state == IDLE) && (flush || flush_pend);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            inst_ready <= 1'b0;
            inst_res   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            beat_q     <= '0;
            line_buf   <= '0;
            fill_tag   <= '0;
            fill_set   <= '0;
            flush_pend <= 1'b0;
            ptr_q      <= '0;
        end else if (rdy_in) begin
            inst_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush || flush_pend) begin
                        // Valid bits clear this edge; the lookup reruns next cycle.
                        flush_pend <= 1'b0;
                    end else if (inst_valid && !inst_ready && !rob_clear) begin
                        // The ready cycle is skipped so a held request yields one pulse.
                        if (!lo_hit) begin
                            fill_tag <= lo_tag;
                            fill_set <= lo_set;
                            mem_addr <= {lo_tag, lo_set, {(LINE_BIT + 2){1'b0}}};
                            mem_req  <= 1'b1;
                            state    <= REFILL;
                        end else if (straddle && !hi_hit) begin
                            fill_tag <= hi_tag;
                            fill_set <= hi_set;
                            mem_addr <= {hi_tag, hi_set, {(LINE_BIT + 2){1'b0}}};
                            mem_req  <= 1'b1;
                            state    <= REFILL;
                        end else begin
                            inst_ready <= 1'b1;
                            inst_res   <= fetch_res;
                        end
                    end
                end
                REFILL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (mem_beat) begin
                        line_buf[{beat_q, 5'b0} +: 32] <= mem_data;
                        if (beat_q == '1) begin
                            beat_q  <= '0;
                            mem_req <= 1'b0;
                            state   <= INSTALL;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                INSTALL: begin
                    if (flush) flush_pend <= 1'b1;
                    if (victim == ptr_q[fill_set]) begin
                        ptr_q[fill_set] <= (ptr_q[fill_set] == PTR_W'(WAYS - 1)) ?
                                           '0 : ptr_q[fill_set] + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc (WAYS=2, SET_BIT=4, LINE_BIT=2).
// Memory word at byte address a is {~a[15:0], a[15:0]}.
module tb_icache_assoc;

    logic        clk, rst, rdy_in;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_addr, inst_res;
    logic        mem_req, mem_beat;
    logic [31:0] mem_addr, mem_data;
    logic        rob_clear, flush;

    int n_cmp = 0;
    int n_bad = 0;

    icache_assoc #(.WAYS(2), .SET_BIT(4), .LINE_BIT(2)) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .rdy_in     (rdy_in),
        .inst_valid (inst_valid),
        .inst_addr  (inst_addr),
        .inst_ready (inst_ready),
        .inst_res   (inst_res),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_beat   (mem_beat),
        .mem_data   (mem_data),
        .rob_clear  (rob_clear),
        .flush      (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic serve_beats(input logic [31:0] base, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            mem_beat = 1'b1;
            mem_data = mem_word(base + 32'(4 * i));
            @(negedge clk);
        end
        mem_beat = 1'b0;
        mem_data = '0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_ready(input int ncyc, output int pulses);
        pulses = 0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            if (inst_ready) pulses++;
        end
    endtask

    // Issue a fetch, serve any refills from the memory model, return the result.
    task automatic run_fetch(input logic [31:0] addr, output logic [31:0] res,
                             output int cycles, output int nreq,
                             output logic [31:0] req0, output logic [31:0] req1);
        @(negedge clk);
        inst_valid = 1'b1;
        inst_addr  = addr;
        res = 'x; cycles = 0; nreq = 0; req0 = '0; req1 = '0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            cycles++;
            if (inst_ready) begin
                res = inst_res;
                break;
            end
            if (mem_req) begin
                if (nreq == 0) req0 = mem_addr; else req1 = mem_addr;
                nreq++;
                serve_beats(mem_addr, 0, 3);
                cycles += 4;
            end
        end
        inst_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        inst_valid = 1'b0; rob_clear = 1'b0; flush = 1'b0;
        mem_beat = 1'b0; rdy_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++; if (inst_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", inst_ready); end
        n_cmp++; if (inst_res !== 32'h0) begin n_bad++; $display("FAIL reset_res: got %h want 0", inst_res); end
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        logic [31:0] res, r0, r1;
        int cyc, nreq;
        do_reset();
        run_fetch(32'h0000_1000, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 1) begin n_bad++; $display("FAIL cold_nreq: got %0d want 1", nreq); end
        n_cmp++; if (r0 !== 32'h0000_1000) begin n_bad++; $display("FAIL cold_addr: got %h want 00001000", r0); end
        n_cmp++; if (res !== 32'hEFFF_1000) begin n_bad++; $display("FAIL cold_res: got %h want efff1000", res); end
        n_cmp++; if (cyc !== 7) begin n_bad++; $display("FAIL cold_cycles: got %0d want 7", cyc); end
        run_fetch(32'h0000_1004, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 0) begin n_bad++; $display("FAIL hit_nreq: got %0d want 0", nreq); end
        n_cmp++; if (cyc !== 1) begin n_bad++; $display("FAIL hit_cycles: got %0d want 1", cyc); end
        n_cmp++; if (res !== 32'hEFFB_1004) begin n_bad++; $display("FAIL hit_res: got %h want effb1004", res); end
    endtask

    task automatic test_straddle();
        logic [31:0] res, r0, r1;
        int cyc, nreq;
        do_reset();
        run_fetch(32'h0000_100E, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 2) begin n_bad++; $display("FAIL strad_nreq: got %0d want 2", nreq); end
        n_cmp++; if (r0 !== 32'h0000_1000) begin n_bad++; $display("FAIL strad_req0: got %h want 00001000", r0); end
        n_cmp++; if (r1 !== 32'h0000_1010) begin n_bad++; $display("FAIL strad_req1: got %h want 00001010", r1); end
        n_cmp++; if (res !== 32'h1010_EFF3) begin n_bad++; $display("FAIL strad_res: got %h want 1010eff3", res); end
        n_cmp++; if (cyc !== 13) begin n_bad++; $display("FAIL strad_cycles: got %0d want 13", cyc); end
        run_fetch(32'h0000_1006, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 0) begin n_bad++; $display("FAIL half_nreq: got %0d want 0", nreq); end
        n_cmp++; if (res !== 32'h1008_EFFB) begin n_bad++; $display("FAIL half_res: got %h want 1008effb", res); end
    endtask

    task automatic test_conflict();
        logic [31:0] res, r0, r1;
        int cyc, nreq;
        do_reset();
        run_fetch(32'h0000_0000, res, cyc, nreq, r0, r1);
        run_fetch(32'h0000_0100, res, cyc, nreq, r0, r1);
        run_fetch(32'h0000_0200, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 1) begin n_bad++; $display("FAIL conf_fill3_nreq: got %0d want 1", nreq); end
        n_cmp++; if (res !== 32'hFDFF_0200) begin n_bad++; $display("FAIL conf_fill3_res: got %h want fdff0200", res); end
        run_fetch(32'h0000_0100, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 0) begin n_bad++; $display("FAIL conf_keep_nreq: got %0d want 0", nreq); end
        n_cmp++; if (res !== 32'hFEFF_0100) begin n_bad++; $display("FAIL conf_keep_res: got %h want feff0100", res); end
        run_fetch(32'h0000_0000, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 1) begin n_bad++; $display("FAIL conf_evict_nreq: got %0d want 1", nreq); end
        n_cmp++; if (res !== 32'hFFFF_0000) begin n_bad++; $display("FAIL conf_evict_res: got %h want ffff0000", res); end
        // Pointer moved on to way 1, so the 0x0200 line in way 0 survived.
        run_fetch(32'h0000_0200, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 0) begin n_bad++; $display("FAIL conf_rr_nreq: got %0d want 0", nreq); end
    endtask

    task automatic test_rob_clear();
        logic [31:0] res, r0, r1;
        int cyc, nreq, pulses;
        bit ok;
        do_reset();
        @(negedge clk);
        inst_valid = 1'b1;
        inst_addr  = 32'h0000_2000;
        wait_req(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rob_req_seen: got %b want 1", ok); end
        serve_beats(32'h0000_2000, 0, 1);
        rob_clear = 1'b1; inst_valid = 1'b0;
        mem_beat = 1'b1; mem_data = mem_word(32'h0000_2008);
        @(negedge clk);
        rob_clear = 1'b0;
        mem_data = mem_word(32'h0000_200C);
        @(negedge clk);
        mem_beat = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rob_burst_done: got %b want 0", mem_req); end
        count_ready(8, pulses);
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rob_no_ready: got %0d want 0", pulses); end
        run_fetch(32'h0000_2008, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 0) begin n_bad++; $display("FAIL rob_line_nreq: got %0d want 0", nreq); end
        n_cmp++; if (res !== 32'hDFF7_2008) begin n_bad++; $display("FAIL rob_line_res: got %h want dff72008", res); end
        // Squash arriving with a hitting request wins.
        @(negedge clk);
        inst_valid = 1'b1; inst_addr = 32'h0000_2004; rob_clear = 1'b1;
        @(negedge clk);
        n_cmp++; if (inst_ready !== 1'b0) begin n_bad++; $display("FAIL rob_prio: got %b want 0", inst_ready); end
        rob_clear = 1'b0; inst_valid = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] res, r0, r1;
        int cyc, nreq, pulses;
        bit ok;
        // Line 0x2000 is warm from the previous scenario.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        run_fetch(32'h0000_2004, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 1) begin n_bad++; $display("FAIL flush_idle_nreq: got %0d want 1", nreq); end
        n_cmp++; if (res !== 32'hDFFB_2004) begin n_bad++; $display("FAIL flush_idle_res: got %h want dffb2004", res); end
        @(negedge clk);
        inst_valid = 1'b1;
        inst_addr  = 32'h0000_3000;
        wait_req(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL flush_req_seen: got %b want 1", ok); end
        flush = 1'b1;
        mem_beat = 1'b1; mem_data = mem_word(32'h0000_3000);
        @(negedge clk);
        flush = 1'b0;
        serve_beats(32'h0000_3000, 1, 3);
        inst_valid = 1'b0;
        count_ready(6, pulses);
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL flush_refill_ready: got %0d want 0", pulses); end
        run_fetch(32'h0000_3000, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 1) begin n_bad++; $display("FAIL flush_refill_nreq: got %0d want 1", nreq); end
        n_cmp++; if (res !== 32'hCFFF_3000) begin n_bad++; $display("FAIL flush_refill_res: got %h want cfff3000", res); end
        // A flush alongside a hitting request suppresses the result.
        @(negedge clk);
        inst_valid = 1'b1; inst_addr = 32'h0000_3000; flush = 1'b1;
        @(negedge clk);
        n_cmp++; if (inst_ready !== 1'b0) begin n_bad++; $display("FAIL flush_suppress: got %b want 0", inst_ready); end
        flush = 1'b0; inst_valid = 1'b0;
    endtask

    task automatic test_rdy_stall();
        logic [31:0] res, r0, r1;
        int cyc, nreq;
        bit ok, got;
        do_reset();
        @(negedge clk);
        inst_valid = 1'b1;
        inst_addr  = 32'h0000_4008;
        wait_req(ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL stall_req_seen: got %b want 1", ok); end
        serve_beats(32'h0000_4000, 0, 1);
        rdy_in = 1'b0;
        mem_beat = 1'b1; mem_data = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL stall_req_held: got %b want 1", mem_req); end
        rdy_in = 1'b1;
        serve_beats(32'h0000_4000, 2, 3);
        got = 1'b0; res = 'x;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (inst_ready) begin
                got = 1'b1;
                res = inst_res;
                break;
            end
        end
        inst_valid = 1'b0;
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL stall_ready: got %b want 1", got); end
        n_cmp++; if (res !== 32'hBFF7_4008) begin n_bad++; $display("FAIL stall_res: got %h want bff74008", res); end
        run_fetch(32'h0000_400C, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 0) begin n_bad++; $display("FAIL stall_hit_nreq: got %0d want 0", nreq); end
        n_cmp++; if (res !== 32'hBFF3_400C) begin n_bad++; $display("FAIL stall_hit_res: got %h want bff3400c", res); end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] res, r0, r1;
        int cyc, nreq;
        bit ok;
        @(negedge clk);
        inst_valid = 1'b1;
        inst_addr  = 32'h0000_5000;
        wait_req(ok);
        serve_beats(32'h0000_5000, 0, 0);
        rst = 1'b1; inst_valid = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_req: got %b want 0", mem_req); end
        @(negedge clk);
        rst = 1'b0;
        run_fetch(32'h0000_5000, res, cyc, nreq, r0, r1);
        n_cmp++; if (nreq !== 1) begin n_bad++; $display("FAIL rstmid_nreq: got %0d want 1", nreq); end
        n_cmp++; if (res !== 32'hAFFF_5000) begin n_bad++; $display("FAIL rstmid_res: got %h want afff5000", res); end
    endtask

    initial begin
        rst = 1'b1; rdy_in = 1'b1;
        inst_valid = 1'b0; inst_addr = '0;
        mem_beat = 1'b0; mem_data = '0;
        rob_clear = 1'b0; flush = 1'b0;
        test_reset();
        test_cold_miss();
        test_straddle();
        test_conflict();
        test_rob_clear();
        test_flush();
        test_rdy_stall();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
